truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequencer that exercises a 4-input combinational logic function: drives all 16 input vectors in order, waits a settle time, and samples the function output.
- Assembles the captured truth table and compares it against an expected 16-bit mask, reporting mismatch count and first failing vector.
- Sits between a host/test controller (start/done handshake) and a combinational block under evaluation (x_out -> DUT inputs X1..X4, DUT output F -> f_in).

Parameters:
- SETTLE, 1, cycles x_out is held before f_in is sampled; legal range 1..15; value 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin scan; sampled only in IDLE.
- abort  input  1  synchronous; cancels a scan in progress.
- expected  input  16  expected truth table, bit i = F for vector i; latched when start is accepted.
- x_out  output  4  applied vector; x_out[3]=X1 (MSB), x_out[2]=X2, x_out[1]=X3, x_out[0]=X4.
- f_in  input  1  output of the combinational block.
- busy  output  1  high from the accept cycle through the last SAMPLE.
- done  output  1  one-cycle pulse when the scan completes.
- table_out  output  16  captured truth table, bit i = sampled F for vector i.
- mismatch_cnt  output  5  number of bits where table_out differs from the latched expected value (0..16).
- pass  output  1  high when mismatch_cnt==0; valid while done is high and held afterwards.
- fail_valid  output  1  at least one mismatch was recorded this scan.
- first_fail  output  4  lowest vector index that mismatched; valid when fail_valid=1.

Behaviour:
- Reset values (asynchronous): state=IDLE, x_out=0, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0, fail_valid=0, first_fail=0, internal idx=0, wait counter=0, latched expected=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 -> latch expected; clear table_out, mismatch_cnt, pass, fail_valid and first_fail; set idx=0 and wait counter=0; go to APPLY.
  - busy goes high on the edge that accepts start.
- APPLY:
  - x_out=idx throughout.
  - The wait counter increments each cycle; when it equals SETTLE-1, go to SAMPLE.
  - APPLY therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle; x_out still equals idx):
  - At the edge, table_out[idx] <= f_in.
  - If f_in != expected[idx]: mismatch_cnt increments; if fail_valid=0, then first_fail <= idx and fail_valid <= 1.
  - If idx==15, go to DONE. Otherwise idx <= idx+1, clear the wait counter, and go to APPLY.
- DONE (one cycle):
  - done=1, busy=0, pass=(mismatch_cnt==0).
  - Next state is IDLE.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - done is high in cycle 16*(SETTLE+1)+1 counted after the start-accept edge; 33 cycles for SETTLE=1.
- x_out order is 0,1,...,15. idx never wraps within a scan. x_out holds 15 after the scan until the next start or reset.
- start while busy or in DONE: ignored; no restart, no queuing.
- start held high continuously: a new scan begins on the cycle after DONE (from IDLE).
- abort=1 in APPLY or SAMPLE:
  - Go to IDLE on the next edge; busy=0; no done pulse.
  - table_out, mismatch_cnt and first_fail keep partial values; pass stays 0.
  - If abort and the final SAMPLE coincide, abort wins: no done.
  - abort in IDLE or DONE has no effect.
- Asynchronous reset mid-scan: all outputs and state return to reset values immediately; the block restarts only on a new start.
- Results hold stable from DONE until the next accepted start.
- Arithmetic: mismatch_cnt is 5 bits; it saturates naturally because the maximum is 16. The wait counter is 4 bits.

Test Plan:
- Reference function F=(X1&X2)|(X3&X4)|((X1|~X2)&(X4|~X3)) connected; SETTLE=1, expected=16'hFB8B, pulse start -> done 33 cycles after accept, table_out=16'hFB8B, mismatch_cnt=0, pass=1, fail_valid=0.
- Same DUT, expected=16'hFB8A -> table_out=16'hFB8B, mismatch_cnt=1, fail_valid=1, first_fail=0, pass=0.
- f_in tied 0, expected=16'hFFFF, SETTLE=3 -> done 65 cycles after accept, table_out=0, mismatch_cnt=16, first_fail=0.
- Start pulsed again at cycle 10 of a scan -> ignored; single done at cycle 33; x_out sequence 0..15 is uninterrupted, each value held 2 cycles.
- abort asserted while x_out=5 -> next cycle IDLE, busy=0, no done pulse; table_out bits 0..4 hold captured values; a fresh start clears the results and rescans from 0.
- rst asserted asynchronously mid-scan (x_out=9) -> all outputs 0 without waiting for a clock edge; after release, no activity until start.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives all 16 vectors into a 4-input function, captures its truth table and compares it to an expected mask
module truth_table_scanner #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic [3:0]  x_out,
  input  logic        f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic        pass,
  output logic        fail_valid,
  output logic [3:0]  first_fail
);
  localparam logic [3:0] WLAST = (SETTLE <= 1) ? 4'd0 : 4'(SETTLE - 1);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] idx, wcnt;
  logic [15:0] exp_q;
  logic pass_q, miss;
  assign miss  = f_in != exp_q[idx];
  assign x_out = idx;
  assign busy  = (state == APPLY) || (state == SAMPLE);
  assign done  = state == DONE;
  assign pass  = done ? (mismatch_cnt == 5'd0) : pass_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? APPLY : IDLE;
      APPLY:   state_nx = abort ? IDLE : (wcnt == WLAST ? SAMPLE : APPLY);
      SAMPLE:  state_nx = abort ? IDLE : (idx == 4'd15 ? DONE : APPLY);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      wcnt         <= '0;
      exp_q        <= '0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      pass_q       <= 1'b0;
      fail_valid   <= 1'b0;
      first_fail   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          exp_q        <= expected;
          table_out    <= '0;
          mismatch_cnt <= '0;
          pass_q       <= 1'b0;
          fail_valid   <= 1'b0;
          first_fail   <= '0;
          idx          <= '0;
          wcnt         <= '0;
        end
        APPLY: if (!abort) wcnt <= wcnt + 4'd1;
        SAMPLE: if (!abort) begin
          table_out[idx] <= f_in;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + 5'd1;
            if (!fail_valid) begin
              first_fail <= idx;
              fail_valid <= 1'b1;
            end
          end
          if (idx != 4'd15) begin
            idx  <= idx + 4'd1;
            wcnt <= '0;
          end
        end
        default: pass_q <= mismatch_cnt == 5'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed scans against a reference 4-input function with a scoreboard of predicted results
module tb_truth_table_scanner;
  logic clk = 1'b0, rst = 1'b1, start1 = 1'b0, start3 = 1'b0, abort = 1'b0;
  logic [15:0] expected = '0;
  logic [3:0] x1, x3, ff1, ff3;
  logic f1, busy1, busy3, done1, done3, pass1, pass3, fv1, fv3;
  logic [15:0] tbl1, tbl3;
  logic [4:0] cnt1, cnt3;
  logic zero = 1'b0;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic        ps;
    logic        fv;
    logic [3:0]  ff;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic model_f(logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    return (a & b) | (c & d) | ((a | ~b) & (d | ~c));
  endfunction

  function automatic logic [15:0] model_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = model_f(4'(i));
    return t;
  endfunction

  function automatic exp_t predict(logic [15:0] tbl, logic [15:0] ex, int settle);
    exp_t e;
    logic [15:0] diff;
    diff = tbl ^ ex;
    e.tbl = tbl;
    e.cnt = '0;
    e.ff = '0;
    for (int i = 15; i >= 0; i--) if (diff[i]) begin
      e.cnt = e.cnt + 5'd1;
      e.ff = 4'(i);
    end
    e.fv = diff != 0;
    e.ps = diff == 0;
    e.lat = 16 * (settle + 1) + 1;
    return e;
  endfunction

  assign f1 = model_f(x1);

  truth_table_scanner #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .expected(expected),
    .x_out(x1), .f_in(f1), .busy(busy1), .done(done1), .table_out(tbl1),
    .mismatch_cnt(cnt1), .pass(pass1), .fail_valid(fv1), .first_fail(ff1)
  );

  truth_table_scanner #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .abort(zero), .expected(expected),
    .x_out(x3), .f_in(zero), .busy(busy3), .done(done3), .table_out(tbl3),
    .mismatch_cnt(cnt3), .pass(pass3), .fail_valid(fv3), .first_fail(ff3)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run(bit sel, logic [15:0] ex, int restart_at);
    exp_t e;
    int k;
    bit got, xok;
    @(negedge clk);
    expected = ex;
    sb.push_back(predict(sel ? 16'h0000 : model_table(), ex, sel ? 3 : 1));
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    chk("busy_on_accept", 32'(sel ? busy3 : busy1), 32'd1);
    chk("cleared_on_accept", 32'(sel ? tbl3 : tbl1), 32'd0);
    k = 1;
    got = 1'b0;
    xok = 1'b1;
    while (k < 200 && !got) begin
      if (!sel && k <= 32 && x1 !== 4'((k - 1) / 2)) xok = 1'b0;
      if (sel ? done3 : done1) got = 1'b1;
      else begin
        start1 = !sel && k == restart_at;
        @(negedge clk);
        k++;
      end
    end
    start1 = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency", 32'(k), 32'(e.lat));
      chk("table_out", 32'(sel ? tbl3 : tbl1), 32'(e.tbl));
      chk("mismatch_cnt", 32'(sel ? cnt3 : cnt1), 32'(e.cnt));
      chk("pass", 32'(sel ? pass3 : pass1), 32'(e.ps));
      chk("fail_valid", 32'(sel ? fv3 : fv1), 32'(e.fv));
      if (e.fv) chk("first_fail", 32'(sel ? ff3 : ff1), 32'(e.ff));
      if (!sel) chk("x_sequence", 32'(xok), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(sel ? done3 : done1), 32'd0);
      chk("pass_held", 32'(sel ? pass3 : pass1), 32'(e.ps));
      chk("busy_after", 32'(sel ? busy3 : busy1), 32'd0);
      chk("x_holds_15", 32'(sel ? x3 : x1), 32'd15);
    end
  endtask

  initial begin
    int n, nd;
    repeat (2) @(negedge clk);
    chk("rst_x_out", 32'(x1), 32'd0);
    chk("rst_busy_done", 32'({busy1, done1, busy3, done3}), 32'd0);
    chk("rst_results", 32'({tbl1, cnt1, pass1, fv1, ff1}), 32'd0);
    rst = 1'b0;
    run(1'b0, 16'hFB8B, 0);
    run(1'b0, 16'hFB8A, 0);
    run(1'b1, 16'hFFFF, 0);
    run(1'b0, 16'h1234, 10);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    chk("no_requeued_scan", 32'(nd), 32'd0);
    expected = 16'hFB8B;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (x1 !== 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x5", 32'(x1), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_partial_table", 32'(tbl1), 32'(model_table() & 16'h001F));
    chk("abort_pass", 32'(pass1), 32'd0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run(1'b0, 16'hFB8B, 0);
    expected = 16'h0F0F;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (x1 !== 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_x9", 32'(x1), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_x_out", 32'(x1), 32'd0);
    chk("async_rst_busy_done", 32'({busy1, done1}), 32'd0);
    chk("async_rst_results", 32'({tbl1, cnt1, pass1, fv1, ff1}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1 || busy1 || x1 != 4'd0) nd++;
    end
    chk("idle_after_rst", 32'(nd), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
